// File: rtl/mdio_cfg_pkg.sv
// Shared types and constants for the MDIO PHY configuration sequencer.
package mdio_cfg_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_PWR  = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_BUSY = 3'd3,
        ST_REL  = 3'd4,
        ST_GAP  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // One table entry: the 24-bit command word handed to the write engine.
    typedef logic [23:0] entry_t;

    // Field positions of a write command.
    localparam int OP_WR_ADDR_MSB = 20;
    localparam int OP_WR_ADDR_LSB = 16;
    localparam int OP_WR_DATA_MSB = 15;
    localparam int OP_WR_DATA_LSB = 0;

    // Build a write command; bits [23:21] stay zero.
    function automatic entry_t op_wr(input logic [4:0] addr, input logic [15:0] data);
        entry_t e;
        e = '0;
        e[OP_WR_ADDR_MSB:OP_WR_ADDR_LSB] = addr;
        e[OP_WR_DATA_MSB:OP_WR_DATA_LSB] = data;
        return e;
    endfunction

    // Default board table: BMCR reset/autoneg, advertisement, 1000BASE-T
    // control, then autoneg restart.
    localparam int ROM_DEPTH = 4;
    localparam entry_t ROM_DEFAULT [ROM_DEPTH] = '{
        op_wr(5'h00, 16'h9140),
        op_wr(5'h04, 16'h01E1),
        op_wr(5'h09, 16'h0200),
        op_wr(5'h00, 16'h1340)
    };

endpackage

// File: rtl/mdio_cfg_seq_if.sv
// Signals between the configuration sequencer, the MDIO write engine and
// the system controller.
interface mdio_cfg_seq_if;
    import mdio_cfg_pkg::*;

    entry_t mdio_data;  // command word to the write engine
    logic   start;      // run request to the write engine
    logic   tr_end;     // write-complete flag from the engine
    logic   go;         // replay request from the controller
    logic   cfg_done;   // table finished or aborted
    logic   cfg_err;    // a write timed out during the last pass

    // Sequencer side.
    modport master (
        output mdio_data, start, cfg_done, cfg_err,
        input  tr_end, go
    );

    // Engine / controller side.
    modport slave (
        input  mdio_data, start, cfg_done, cfg_err,
        output tr_end, go
    );

endinterface

// File: rtl/mdio_cfg_seq_rom.sv
// Combinational register-write table; swap this module to retarget a board.
module mdio_cfg_rom
    import mdio_cfg_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic [3:0] idx,
    output entry_t     word
);

    entry_t rom_tbl [16];

    // Entries past the active count (or past the default table) read zero.
    for (genvar gi = 0; gi < 16; gi++) begin : g_tbl
        if (gi < NUM_REGS && gi < ROM_DEPTH) begin : g_used
            assign rom_tbl[gi] = ROM_DEFAULT[gi];
        end else begin : g_zero
            assign rom_tbl[gi] = '0;
        end
    end

    assign word = rom_tbl[idx];

endmodule

// File: rtl/mdio_cfg_seq.sv
// PHY configuration sequencer: waits out PHY power-up, then issues each
// table entry to the MDIO write engine, one start/tr_end handshake per write.
module mdio_cfg_seq
    import mdio_cfg_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int PWR_WAIT = 1000,
    parameter int GAP      = 4,
    parameter int TIMEOUT  = 63
) (
    input  logic           mdc,
    input  logic           reset_n,
    mdio_cfg_seq_if.master bus
);

    localparam int              TO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [15:0]     PWR_LAST = 16'(PWR_WAIT - 1);
    localparam logic [15:0]     GAP_LAST = 16'(GAP - 1);
    localparam logic [3:0]      IDX_LAST = 4'(NUM_REGS - 1);

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [15:0]     cnt_q, cnt_d;        // shared by power-up wait and gap
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;  // cycles spent in BUSY
    entry_t          data_q, data_d;
    logic            start_q, start_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [3:0]      rom_idx;
    entry_t          rom_word;

    mdio_cfg_rom #(.NUM_REGS(NUM_REGS)) u_rom (
        .idx  (rom_idx),
        .word (rom_word)
    );

    // Index of the entry that LOAD will fetch on the next edge: the next one
    // when leaving GAP, entry 0 on a replay, otherwise the current one.
    always_comb begin
        rom_idx = idx_q;
        if (state_q == ST_GAP) begin
            rom_idx = idx_q + 4'd1;
        end else if (state_q == ST_DONE) begin
            rom_idx = 4'd0;
        end
    end

    // Next-state and output computation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        to_cnt_d = to_cnt_q;
        data_d   = data_q;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            ST_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_LOAD: begin
                state_d = ST_ARM;
            end
            ST_ARM: begin
                to_cnt_d = '0;
                state_d  = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.tr_end) begin
                    state_d = ST_REL;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_REL: begin
                // The engine drops tr_end once its bit counter is back at 0.
                if (!bus.tr_end) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                if (bus.go) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = 4'd0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_PWR;
            end
        endcase

        // The command word only changes on entry to LOAD, so it is stable
        // for the whole time start is high.
        if (state_d == ST_LOAD) begin
            data_d = rom_word;
        end
        // start is high exactly in ARM and BUSY; LOAD always precedes ARM,
        // giving the engine at least two low cycles to re-zero its counter.
        start_d = (state_d == ST_ARM) || (state_d == ST_BUSY);
    end

    // State and output registers.
    always_ff @(posedge mdc or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_PWR;
            idx_q    <= '0;
            cnt_q    <= '0;
            to_cnt_q <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
            data_q   <= data_d;
            start_q  <= start_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.mdio_data = data_q;
    assign bus.start     = start_q;
    assign bus.cfg_done  = done_q;
    assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_mdio_cfg_seq.sv
// Directed bench for mdio_cfg_seq with a behavioural MDIO write engine.
module tb_mdio_cfg_seq;

    localparam int NUM_REGS = 4;
    localparam int PWR_WAIT = 10;
    localparam int GAP      = 4;
    localparam int TIMEOUT  = 63;
    localparam int TR_DLY   = 34;

    logic mdc     = 1'b0;
    logic reset_n = 1'b1;
    logic go_r    = 1'b0;
    logic eng_tr  = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_tbl [4] = '{24'h009140, 24'h0401E1, 24'h090200, 24'h001340};

    mdio_cfg_seq_if bus();

    assign bus.tr_end = eng_tr;
    assign bus.go     = go_r;

    mdio_cfg_seq #(
        .NUM_REGS (NUM_REGS),
        .PWR_WAIT (PWR_WAIT),
        .GAP      (GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .mdc     (mdc),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 mdc = ~mdc;

    // Engine model: counts mdc cycles while start is high, raises tr_end on
    // the falling edge TR_DLY cycles in, clears it hold_len cycles after
    // start falls.
    int eng_cnt  = 63;
    int hold_cnt = 0;
    int hold_len = 0;
    bit tie_low  = 1'b0;

    always @(negedge mdc) begin
        if (!bus.start) begin
            eng_cnt <= 0;
            if (eng_tr && hold_cnt < hold_len) begin
                hold_cnt <= hold_cnt + 1;
            end else begin
                eng_tr   <= 1'b0;
                hold_cnt <= 0;
            end
        end else begin
            hold_cnt <= 0;
            if (eng_cnt < 63) eng_cnt <= eng_cnt + 1;
            if (eng_cnt + 1 == TR_DLY && !tie_low) eng_tr <= 1'b1;
        end
    end

    // Transaction monitor: records the command word at each start rise.
    logic        prev_start = 1'b0;
    logic [23:0] prev_data  = '0;
    logic [23:0] cap [$];
    int          unstable   = 0;

    always @(posedge mdc) begin
        #2;
        if (bus.start && !prev_start) begin
            cap.push_back(bus.mdio_data);
            $display("xfer %0d data=%06h t=%0t", cap.size() - 1, bus.mdio_data, $time);
        end
        if (bus.start && prev_start && bus.mdio_data !== prev_data) unstable++;
        prev_start = bus.start;
        prev_data  = bus.mdio_data;
    end

    task automatic tick();
        @(negedge mdc);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        go_r    = 1'b0;
        tick();
        tick();
        cap.delete();
        unstable = 0;
        reset_n  = 1'b1;
    endtask

    // Cycles until start is seen high, or -1 on expiry.
    task automatic wait_start_rise(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (bus.start) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.cfg_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", bus.start); end
        checks++;
        if (bus.mdio_data !== 24'h0) begin failures++; $display("FAIL reset_data got=%06h want=000000", bus.mdio_data); end
        checks++;
        if (bus.cfg_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.cfg_done); end
        checks++;
        if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.cfg_err); end
    endtask

    task automatic test_pwr_wait();
        int n;
        do_reset();
        wait_start_rise(n);
        checks++;
        if (n != PWR_WAIT + 1) begin failures++; $display("FAIL pwr_wait_cycles got=%0d want=%0d", n, PWR_WAIT + 1); end
        checks++;
        if (bus.mdio_data !== exp_tbl[0]) begin failures++; $display("FAIL pwr_first_word got=%06h want=%06h", bus.mdio_data, exp_tbl[0]); end
    endtask

    task automatic test_sequence();
        bit ok;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL seq_done_timeout got=0 want=1"); end
        checks++;
        if (cap.size() != NUM_REGS) begin failures++; $display("FAIL seq_count got=%0d want=%0d", cap.size(), NUM_REGS); end
        for (int i = 0; i < NUM_REGS && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp_tbl[i]) begin failures++; $display("FAIL seq_word%0d got=%06h want=%06h", i, cap[i], exp_tbl[i]); end
        end
        checks++;
        if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL seq_err got=%b want=0", bus.cfg_err); end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL seq_data_stable got=%0d want=0", unstable); end
        repeat (5) tick();
        checks++;
        if (bus.cfg_done !== 1'b1 || bus.start !== 1'b0) begin
            failures++; $display("FAIL seq_done_level got=%b/%b want=1/0", bus.cfg_done, bus.start);
        end
    endtask

    task automatic test_go_in_busy();
        int n;
        bit ok;
        do_reset();
        wait_start_rise(n);
        repeat (5) tick();
        go_r = 1'b1;
        tick();
        go_r = 1'b0;
        checks++;
        if (bus.start !== 1'b1 || bus.mdio_data !== exp_tbl[0]) begin
            failures++; $display("FAIL busy_go_start got=%b/%06h want=1/%06h", bus.start, bus.mdio_data, exp_tbl[0]);
        end
        wait_done(ok);
        checks++;
        if (!ok || cap.size() != NUM_REGS) begin
            failures++; $display("FAIL busy_go_count got=%0d want=%0d", cap.size(), NUM_REGS);
        end
    endtask

    task automatic test_replay(input logic [23:0] last_word);
        int n;
        bit ok;
        cap.delete();
        go_r = 1'b1;
        tick();
        go_r = 1'b0;
        checks++;
        if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
            failures++; $display("FAIL replay_clear got=%b/%b want=0/0", bus.cfg_done, bus.cfg_err);
        end
        wait_start_rise(n);
        checks++;
        if (n != 1) begin failures++; $display("FAIL replay_latency got=%0d want=1", n); end
        checks++;
        if (bus.mdio_data !== exp_tbl[0]) begin failures++; $display("FAIL replay_word0 got=%06h want=%06h", bus.mdio_data, exp_tbl[0]); end
        wait_done(ok);
        checks++;
        if (!ok || cap.size() != NUM_REGS) begin failures++; $display("FAIL replay_count got=%0d want=%0d", cap.size(), NUM_REGS); end
        if (cap.size() == NUM_REGS) begin
            checks++;
            if (cap[NUM_REGS-1] !== last_word) begin failures++; $display("FAIL replay_last got=%06h want=%06h", cap[NUM_REGS-1], last_word); end
        end
    endtask

    task automatic test_rel_hold();
        int  n;
        int  held;
        bit  ok;
        bit  bad;
        do_reset();
        hold_len = 5;
        wait_start_rise(n);
        for (int i = 0; i < 200 && bus.start; i++) tick();
        held = 0;
        bad  = 1'b0;
        for (int i = 0; i < 50 && bus.tr_end; i++) begin
            if (bus.start !== 1'b0 || bus.mdio_data !== exp_tbl[0]) bad = 1'b1;
            held++;
            tick();
        end
        checks++;
        if (bad || held != 5) begin failures++; $display("FAIL rel_hold got=held%0d/bad%0d want=held5/bad0", held, bad); end
        wait_start_rise(n);
        checks++;
        if (n != GAP + 2) begin failures++; $display("FAIL rel_gap got=%0d want=%0d", n, GAP + 2); end
        checks++;
        if (bus.mdio_data !== exp_tbl[1]) begin failures++; $display("FAIL rel_next_word got=%06h want=%06h", bus.mdio_data, exp_tbl[1]); end
        hold_len = 0;
        wait_done(ok);
        checks++;
        if (!ok || bus.cfg_err !== 1'b0) begin failures++; $display("FAIL rel_finish got=%b/%b want=1/0", ok, bus.cfg_err); end
    endtask

    task automatic test_timeout();
        int n;
        int high;
        tie_low = 1'b1;
        do_reset();
        wait_start_rise(n);
        high = 0;
        for (int i = 0; i < 200 && bus.start; i++) begin
            high++;
            tick();
        end
        checks++;
        if (high != TIMEOUT + 1) begin failures++; $display("FAIL to_start_high got=%0d want=%0d", high, TIMEOUT + 1); end
        checks++;
        if (bus.cfg_done !== 1'b1 || bus.cfg_err !== 1'b1) begin
            failures++; $display("FAIL to_flags got=%b/%b want=1/1", bus.cfg_done, bus.cfg_err);
        end
        repeat (20) tick();
        checks++;
        if (cap.size() != 1 || bus.start !== 1'b0 || bus.mdio_data !== exp_tbl[0]) begin
            failures++; $display("FAIL to_no_next got=%0d/%b/%06h want=1/0/%06h", cap.size(), bus.start, bus.mdio_data, exp_tbl[0]);
        end
        tie_low = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int n;
        bit ok;
        bit hit;
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (cap.size() == 2 && eng_cnt == 20) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL mid_reach got=0 want=1"); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.start !== 1'b0 || bus.mdio_data !== 24'h0 || bus.cfg_done !== 1'b0) begin
            failures++; $display("FAIL mid_async got=%b/%06h/%b want=0/000000/0", bus.start, bus.mdio_data, bus.cfg_done);
        end
        tick();
        cap.delete();
        reset_n = 1'b1;
        wait_start_rise(n);
        checks++;
        if (n != PWR_WAIT + 1 || bus.mdio_data !== exp_tbl[0]) begin
            failures++; $display("FAIL mid_restart got=%0d/%06h want=%0d/%06h", n, bus.mdio_data, PWR_WAIT + 1, exp_tbl[0]);
        end
        wait_done(ok);
        checks++;
        if (!ok || cap.size() != NUM_REGS) begin failures++; $display("FAIL mid_count got=%0d want=%0d", cap.size(), NUM_REGS); end
    endtask

    initial begin
        test_reset();
        test_pwr_wait();
        test_sequence();
        test_go_in_busy();
        test_replay(exp_tbl[3]);
        test_rel_hold();
        test_timeout();
        test_replay(exp_tbl[3]);
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
